// File: rtl/our_data_type_one_pkg.sv
// Shared definitions for the type-ONE packet transmitter and receiver.
// This package holds the FSM state encoding, the default packet geometry and
// the total packet length.
package our_data_type_one_pkg;

   // Packet sequencing states, shared by the transmitter and the receiver
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HEADER  = 2'd1,
      ST_PAYLOAD = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   // Default geometry: header bytes and 16-bit payload words per packet
   localparam int HDR_LEN_DEF   = 124;
   localparam int PAY_WORDS_DEF = 200;

   // Total bytes on the wire for a packet with the given geometry
   function automatic int pkt_len(input int hdr_len, input int pay_words);
      return hdr_len + 2 * pay_words;
   endfunction

   localparam int PKT_LEN_DEF = pkt_len(HDR_LEN_DEF, PAY_WORDS_DEF);

endpackage

// File: rtl/our_data_type_one_tx.sv
// Type-ONE packet transmitter: streams HDR_LEN header bytes read from an
// async-read RAM, then PAY_WORDS 16-bit words from a show-ahead FIFO (high
// byte first), over a valid/ready byte interface with registered outputs.
// Optional macro OUR_TX_PKT_CNT_EN adds a 16-bit completed-packet counter.
//
// The FSM state tracks what is being *loaded* into the output register; the
// register itself drains one cycle later, so the last header byte and the
// first payload byte overlap without a bubble. After the final low byte is
// loaded the machine waits in PAYLOAD for it to be taken before pulsing done.
// hdr_addr is 7 bits wide, so HDR_LEN must not exceed 128.
module our_data_type_one_tx
   import our_data_type_one_pkg::*;
#(
   parameter int HDR_LEN   = HDR_LEN_DEF,
   parameter int PAY_WORDS = PAY_WORDS_DEF
) (
   input  logic        clock,
   input  logic        aclr_n,
   input  logic        sclr,
   input  logic        start,
   output logic [6:0]  hdr_addr,
   input  logic [7:0]  hdr_byte,
   input  logic [15:0] fifo_q,
   input  logic        fifo_empty,
   output logic        fifo_rdreq,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        busy,
   output logic        done
`ifdef OUR_TX_PKT_CNT_EN
   ,
   output logic [15:0] pkt_cnt
`endif
);

   localparam int WCW = (PAY_WORDS > 1) ? $clog2(PAY_WORDS) : 1;
   localparam logic [6:0]     HDR_LAST = 7'(HDR_LEN - 1);
   localparam logic [WCW-1:0] WRD_LAST = WCW'(PAY_WORDS - 1);

   state_t         state_reg;
   logic [6:0]     hdr_addr_reg;
   logic [WCW-1:0] word_cnt_reg;
   logic           lo_phase_reg;     // high byte of current word already loaded
   logic           last_loaded_reg;  // final payload byte sits in tx_data
   logic [7:0]     tx_data_reg;
   logic           tx_valid_reg;
   logic           busy_reg;
   logic           done_reg;

   logic           can_load;
   logic           pop;

   // Output register may take a new byte when empty or being transferred now
   assign can_load = !tx_valid_reg || tx_ready;

   // Pop the FIFO head in the same cycle its low byte is loaded
   assign pop = (state_reg == ST_PAYLOAD) && lo_phase_reg && !last_loaded_reg &&
                can_load && !fifo_empty && !sclr;

   assign hdr_addr   = hdr_addr_reg;
   assign fifo_rdreq = pop;
   assign tx_data    = tx_data_reg;
   assign tx_valid   = tx_valid_reg;
   assign busy       = busy_reg;
   assign done       = done_reg;

   // Packet sequencer and byte serializer
   always_ff @(posedge clock or negedge aclr_n) begin
      if (!aclr_n) begin
         state_reg       <= ST_IDLE;
         hdr_addr_reg    <= '0;
         word_cnt_reg    <= '0;
         lo_phase_reg    <= 1'b0;
         last_loaded_reg <= 1'b0;
         tx_data_reg     <= '0;
         tx_valid_reg    <= 1'b0;
         busy_reg        <= 1'b0;
         done_reg        <= 1'b0;
      end else if (sclr) begin
         state_reg       <= ST_IDLE;
         hdr_addr_reg    <= '0;
         word_cnt_reg    <= '0;
         lo_phase_reg    <= 1'b0;
         last_loaded_reg <= 1'b0;
         tx_data_reg     <= '0;
         tx_valid_reg    <= 1'b0;
         busy_reg        <= 1'b0;
         done_reg        <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (start) begin
                  state_reg       <= ST_HEADER;
                  busy_reg        <= 1'b1;
                  hdr_addr_reg    <= '0;
                  word_cnt_reg    <= '0;
                  lo_phase_reg    <= 1'b0;
                  last_loaded_reg <= 1'b0;
               end
            end

            ST_HEADER: begin
               if (can_load) begin
                  tx_data_reg  <= hdr_byte;
                  tx_valid_reg <= 1'b1;
                  if (hdr_addr_reg == HDR_LAST) begin
                     hdr_addr_reg <= '0;
                     state_reg    <= ST_PAYLOAD;
                  end else begin
                     hdr_addr_reg <= hdr_addr_reg + 7'd1;
                  end
               end
            end

            ST_PAYLOAD: begin
               if (last_loaded_reg) begin
                  if (tx_ready) begin
                     tx_valid_reg <= 1'b0;
                     done_reg     <= 1'b1;
                     state_reg    <= ST_DONE;
                  end
               end else if (can_load) begin
                  if (lo_phase_reg && !fifo_empty) begin
                     tx_data_reg  <= fifo_q[7:0];
                     tx_valid_reg <= 1'b1;
                     lo_phase_reg <= 1'b0;
                     if (word_cnt_reg == WRD_LAST)
                        last_loaded_reg <= 1'b1;
                     else
                        word_cnt_reg <= word_cnt_reg + WCW'(1);
                  end else if (!lo_phase_reg && !fifo_empty) begin
                     tx_data_reg  <= fifo_q[15:8];
                     tx_valid_reg <= 1'b1;
                     lo_phase_reg <= 1'b1;
                  end else begin
                     // FIFO starved: drop valid and wait, nothing is padded
                     tx_valid_reg <= 1'b0;
                  end
               end
            end

            ST_DONE: begin
               done_reg  <= 1'b0;
               busy_reg  <= 1'b0;
               state_reg <= ST_IDLE;
            end

            default: state_reg <= ST_IDLE;
         endcase
      end
   end

`ifdef OUR_TX_PKT_CNT_EN
   logic [15:0] pkt_cnt_reg;

   // Count completed packets; wraps naturally at 16 bits
   always_ff @(posedge clock or negedge aclr_n) begin
      if (!aclr_n)
         pkt_cnt_reg <= '0;
      else if (sclr)
         pkt_cnt_reg <= '0;
      else if (state_reg == ST_DONE)
         pkt_cnt_reg <= pkt_cnt_reg + 16'd1;
   end

   assign pkt_cnt = pkt_cnt_reg;
`endif

endmodule
